br_outcome_queue: RTL and testbench

//  Tracks every in-flight conditional-branch prediction from fetch until commit and

---
 rtl/br_outcome_queue.sv | 165 ++++++++++++++++
 tb/tb_br_outcome_queue.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/br_outcome_queue.sv
// Branch outcome queue: tracks in-flight conditional-branch predictions from fetch
// to commit and emits the in-order training stream for the branch predictor.
module br_outcome_queue #(
   parameter  int unsigned PRED_D   = 8,
   parameter  int unsigned SIMBRF   = 2,
   parameter  int unsigned SIMBRCOM = 2,
   localparam int unsigned TAGW     = $clog2(PRED_D)
) (
   input  logic                   clk,
   input  logic                   reset_,
   input  logic                   flush_,
   input  logic [SIMBRF-1:0]      alloc_,
   input  logic [SIMBRF-1:0]      alloc_pred,
   output logic [SIMBRF*TAGW-1:0] alloc_tag,
   output logic                   full,
   input  logic                   res_,
   input  logic [TAGW-1:0]        res_tag,
   input  logic                   res_taken_,
   input  logic [SIMBRCOM-1:0]    com_,
   output logic [SIMBRCOM-1:0]    br_commit_,
   output logic [SIMBRCOM-1:0]    br_taken_,
   output logic [SIMBRCOM-1:0]    br_pred_miss_,
   output logic                   err
);

   localparam int unsigned PW = TAGW + 1;

   logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
   logic [PRED_D-1:0]   valid_q, valid_d;
   logic [PRED_D-1:0]   pred_q, pred_d;
   logic [PRED_D-1:0]   resolved_q, resolved_d;
   logic [PRED_D-1:0]   taken_q, taken_d;
   logic [SIMBRCOM-1:0] fb_commit_q, fb_commit_d;
   logic [SIMBRCOM-1:0] fb_taken_q, fb_taken_d;
   logic [SIMBRCOM-1:0] fb_miss_q, fb_miss_d;
   logic                err_q, err_d;

   logic [PW-1:0]       count;
   logic [PW-1:0]       n_alloc;
   logic [PW-1:0]       n_com;
   logic                alloc_run, alloc_ok;
   logic                com_run;
   logic                res_eff;
   logic                res_hit;
   logic                ent_res, ent_taken;
   logic [TAGW-1:0]     idx;

   assign count = tail_q - head_q;
   assign full  = (PRED_D - 32'(count)) < SIMBRF;

   always_comb begin
      for (int unsigned i = 0; i < SIMBRF; i++) begin
         alloc_tag[i*TAGW +: TAGW] = tail_q[TAGW-1:0] + TAGW'(i);
      end
   end

   always_comb begin
      valid_d     = valid_q;
      pred_d      = pred_q;
      resolved_d  = resolved_q;
      taken_d     = taken_q;
      head_d      = head_q;
      tail_d      = tail_q;
      fb_commit_d = '1;
      fb_taken_d  = '1;
      fb_miss_d   = '1;
      err_d       = 1'b0;
      n_alloc     = '0;
      n_com       = '0;
      alloc_run   = 1'b1;
      com_run     = 1'b1;
      res_hit     = 1'b0;
      ent_res     = 1'b0;
      ent_taken   = 1'b0;
      idx         = '0;

      // Resolutions and allocations are dropped in a flush cycle; commits are not.
      res_eff = ~res_ & flush_;

      for (int unsigned i = 0; i < SIMBRF; i++) begin
         alloc_run = alloc_run & ~alloc_[i];
         if (alloc_run) n_alloc = n_alloc + PW'(1);
      end
      alloc_ok = flush_ & ~full & (n_alloc != '0);

      if (res_eff && valid_q[res_tag]) begin
         resolved_d[res_tag] = 1'b1;
         taken_d[res_tag]    = ~res_taken_;
      end

      // Same-cycle resolution of a retiring entry is forwarded into its feedback.
      for (int unsigned i = 0; i < SIMBRCOM; i++) begin
         com_run = com_run & ~com_[i] & (PW'(i) < count);
         idx     = head_q[TAGW-1:0] + TAGW'(i);
         if (com_run) begin
            res_hit   = res_eff && (res_tag == idx) && valid_q[idx];
            ent_res   = resolved_q[idx] | res_hit;
            ent_taken = res_hit ? ~res_taken_ : taken_q[idx];
            if (ent_res) begin
               fb_commit_d[i] = 1'b0;
               fb_taken_d[i]  = ~ent_taken;
               fb_miss_d[i]   = ~(ent_taken ^ pred_q[idx]);
            end else begin
               err_d = 1'b1;
            end
            valid_d[idx]    = 1'b0;
            resolved_d[idx] = 1'b0;
            n_com           = n_com + PW'(1);
         end
      end
      head_d = head_q + n_com;

      if (alloc_ok) begin
         for (int unsigned i = 0; i < SIMBRF; i++) begin
            idx = tail_q[TAGW-1:0] + TAGW'(i);
            if (PW'(i) < n_alloc) begin
               valid_d[idx]    = 1'b1;
               pred_d[idx]     = alloc_pred[i];
               resolved_d[idx] = 1'b0;
               taken_d[idx]    = 1'b0;
            end
         end
         tail_d = tail_q + n_alloc;
      end

      if (!flush_) begin
         valid_d    = '0;
         resolved_d = '0;
         head_d     = '0;
         tail_d     = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         head_q      <= '0;
         tail_q      <= '0;
         valid_q     <= '0;
         pred_q      <= '0;
         resolved_q  <= '0;
         taken_q     <= '0;
         fb_commit_q <= '1;
         fb_taken_q  <= '1;
         fb_miss_q   <= '1;
         err_q       <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         valid_q     <= valid_d;
         pred_q      <= pred_d;
         resolved_q  <= resolved_d;
         taken_q     <= taken_d;
         fb_commit_q <= fb_commit_d;
         fb_taken_q  <= fb_taken_d;
         fb_miss_q   <= fb_miss_d;
         err_q       <= err_d;
      end
   end

   assign br_commit_    = fb_commit_q;
   assign br_taken_     = fb_taken_q;
   assign br_pred_miss_ = fb_miss_q;
   assign err           = err_q;

endmodule

// File: tb/tb_br_outcome_queue.sv
// Directed bench for br_outcome_queue (PRED_D=8, two fetch and two commit lanes).
module tb_br_outcome_queue;

   logic       clk = 1'b0;
   logic       reset_, flush_, res_, res_taken_, full, err;
   logic [1:0] alloc_, alloc_pred, com_, br_commit_, br_taken_, br_pred_miss_;
   logic [5:0] alloc_tag;
   logic [2:0] res_tag;

   int total = 0;
   int bad   = 0;

   br_outcome_queue #(.PRED_D(8), .SIMBRF(2), .SIMBRCOM(2)) dut (
      .clk(clk), .reset_(reset_), .flush_(flush_),
      .alloc_(alloc_), .alloc_pred(alloc_pred), .alloc_tag(alloc_tag), .full(full),
      .res_(res_), .res_tag(res_tag), .res_taken_(res_taken_),
      .com_(com_), .br_commit_(br_commit_), .br_taken_(br_taken_),
      .br_pred_miss_(br_pred_miss_), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      flush_ = 1'b1; alloc_ = 2'b11; alloc_pred = 2'b00;
      res_ = 1'b1; res_tag = 3'd0; res_taken_ = 1'b1; com_ = 2'b11;
   endtask

   task automatic tick();
      @(posedge clk); #1;
      idle();
   endtask

   task automatic fb(input string tag, input logic [1:0] c, input logic [1:0] t,
                     input logic [1:0] m, input logic e);
      chk({tag, ".commit"}, 32'(br_commit_), 32'(c));
      chk({tag, ".taken"},  32'(br_taken_),  32'(t));
      chk({tag, ".miss"},   32'(br_pred_miss_), 32'(m));
      chk({tag, ".err"},    32'(err), 32'(e));
   endtask

   initial begin
      logic       a, b, p0, p1;
      logic [2:0] t0, t1;
      logic [1:0] kk;

      reset_ = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      fb("rst", 2'b11, 2'b11, 2'b11, 1'b0);
      chk("rst.full", 32'(full), 0);
      chk("rst.tag",  32'(alloc_tag), 32'h08);
      @(negedge clk) reset_ = 1'b1;
      tick();

      // 1: two lanes, pred {lane1=0, lane0=1}, both taken
      alloc_ = 2'b00; alloc_pred = 2'b01; #1;
      chk("t1.tag", 32'(alloc_tag), 32'h08);
      tick();
      res_ = 1'b0; res_tag = 3'd0; res_taken_ = 1'b0; tick();
      res_ = 1'b0; res_tag = 3'd1; res_taken_ = 1'b0; tick();
      com_ = 2'b00; tick();
      fb("t1", 2'b00, 2'b00, 2'b01, 1'b0);
      tick();
      fb("t1.after", 2'b11, 2'b11, 2'b11, 1'b0);

      // 3: same-cycle resolve + commit of tag 2 (pred 0, taken)
      alloc_ = 2'b10; alloc_pred = 2'b00; #1;
      chk("t3.tag", 32'(alloc_tag), 32'h1A);
      tick();
      res_ = 1'b0; res_tag = 3'd2; res_taken_ = 1'b0; com_ = 2'b10; tick();
      fb("t3", 2'b10, 2'b10, 2'b10, 1'b0);

      // 4: commit unresolved head (tag 3)
      alloc_ = 2'b10; tick();
      com_ = 2'b10; tick();
      fb("t4", 2'b11, 2'b11, 2'b11, 1'b1);
      tick();
      chk("t4.errclr", 32'(err), 0);
      chk("t4.tag", 32'(alloc_tag), 32'h2C);

      // 2: fill to 7 (tags 4..7,0,1,2), all pred 0
      repeat (3) begin alloc_ = 2'b00; tick(); end
      chk("t2.full6", 32'(full), 0);
      alloc_ = 2'b10; tick();
      chk("t2.full7", 32'(full), 1);
      alloc_ = 2'b00; res_ = 1'b0; res_tag = 3'd4; res_taken_ = 1'b0; #1;
      chk("t2.tagfull", 32'(alloc_tag), 32'h23);
      tick();
      chk("t2.notail", 32'(alloc_tag), 32'h23);
      chk("t2.stillfull", 32'(full), 1);
      com_ = 2'b10; tick();
      chk("t2.freed", 32'(full), 0);
      fb("t2.com", 2'b10, 2'b10, 2'b10, 1'b0);
      alloc_ = 2'b00; #1;
      chk("t2.tagacc", 32'(alloc_tag), 32'h23);
      tick();
      chk("t2.full8", 32'(full), 1);
      chk("t2.tag8", 32'(alloc_tag), 32'h35);
      com_ = 2'b00; tick();
      fb("t2.drainA", 2'b11, 2'b11, 2'b11, 1'b1);
      com_ = 2'b00; tick();
      fb("t2.drainB", 2'b11, 2'b11, 2'b11, 1'b1);

      // 6: flush with 4 in flight; head (tag 1, pred 0) resolved not-taken
      res_ = 1'b0; res_tag = 3'd1; res_taken_ = 1'b1; tick();
      flush_ = 1'b0; com_ = 2'b10; alloc_ = 2'b00; res_ = 1'b0; res_tag = 3'd2; tick();
      fb("t6.flush", 2'b10, 2'b11, 2'b11, 1'b0);
      chk("t6.full", 32'(full), 0);
      chk("t6.tag", 32'(alloc_tag), 32'h08);
      com_ = 2'b10; tick();
      fb("t6.empty", 2'b11, 2'b11, 2'b11, 1'b0);

      // 5: 3*PRED_D round trips, tags wrap
      for (int k = 0; k < 12; k++) begin
         kk = 2'(k);
         p0 = kk[0]; p1 = kk[1];
         a  = (k % 3) == 0;
         b  = ((k >> 1) & 1) != ((k >> 2) & 1);
         t0 = 3'((2 * k) % 8);
         t1 = 3'((2 * k + 1) % 8);
         alloc_ = 2'b00; alloc_pred = {p1, p0}; #1;
         chk("t5.tag", 32'(alloc_tag), {26'd0, t1, t0});
         tick();
         res_ = 1'b0; res_tag = t0; res_taken_ = ~a; tick();
         res_ = 1'b0; res_tag = t1; res_taken_ = ~b; com_ = 2'b00; tick();
         fb("t5", 2'b00, {~b, ~a}, {~(b ^ p1), ~(a ^ p0)}, 1'b0);
      end

      // 6b: async reset with feedback on the outputs
      alloc_ = 2'b00; alloc_pred = 2'b11; tick();
      res_ = 1'b0; res_tag = 3'd0; res_taken_ = 1'b0; tick();
      res_ = 1'b0; res_tag = 3'd1; res_taken_ = 1'b0; com_ = 2'b00; tick();
      fb("t6b.pre", 2'b00, 2'b00, 2'b11, 1'b0);
      chk("t6b.pretag", 32'(alloc_tag), 32'h1A);
      #2 reset_ = 1'b0; #1;
      fb("t6b.rst", 2'b11, 2'b11, 2'b11, 1'b0);
      chk("t6b.tag", 32'(alloc_tag), 32'h08);
      chk("t6b.full", 32'(full), 0);
      @(negedge clk) reset_ = 1'b1;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
